// File: rtl/tl_ul_arbiter_2to1.sv
// tl_ul_arbiter_2to1
// Shares one TileLink-UL slave port between two TL-UL masters.
//   A channel: round-robin grant, held for the whole of a multi-beat Put.
//              The winning requester index is prepended as the source MSB.
//   D channel: routed back by that source MSB, which is stripped on delivery.
//   Each requester is limited to MAX_OUTST outstanding messages.
// Ports:
//   clock, reset            sole clock, asynchronous active-high reset
//   in0_a_*, in1_a_*        upstream A channels (valid/ready + fields)
//   in0_d_*, in1_d_*        upstream D channels (valid/ready + fields)
//   out_a_*                 shared downstream A channel (source is SOURCE_W+1)
//   out_d_*                 shared downstream D channel (source is SOURCE_W+1)
//
// state | meaning
// IDLE  | combinational round-robin grant between eligible requesters
// BURST | grant locked to `lock` until the remaining Put beats have fired
module tl_ul_arbiter_2to1 #(
  parameter int SOURCE_W  = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 64,
  parameter int SIZE_W    = 3,
  parameter int MAX_OUTST = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in0_a_valid,
  output logic                  in0_a_ready,
  input  logic [2:0]            in0_a_opcode,
  input  logic [SIZE_W-1:0]     in0_a_size,
  input  logic [SOURCE_W-1:0]   in0_a_source,
  input  logic [ADDR_W-1:0]     in0_a_address,
  input  logic [DATA_W/8-1:0]   in0_a_mask,
  input  logic [DATA_W-1:0]     in0_a_data,
  output logic                  in0_d_valid,
  input  logic                  in0_d_ready,
  output logic [2:0]            in0_d_opcode,
  output logic [SIZE_W-1:0]     in0_d_size,
  output logic [SOURCE_W-1:0]   in0_d_source,
  output logic [DATA_W-1:0]     in0_d_data,
  input  logic                  in1_a_valid,
  output logic                  in1_a_ready,
  input  logic [2:0]            in1_a_opcode,
  input  logic [SIZE_W-1:0]     in1_a_size,
  input  logic [SOURCE_W-1:0]   in1_a_source,
  input  logic [ADDR_W-1:0]     in1_a_address,
  input  logic [DATA_W/8-1:0]   in1_a_mask,
  input  logic [DATA_W-1:0]     in1_a_data,
  output logic                  in1_d_valid,
  input  logic                  in1_d_ready,
  output logic [2:0]            in1_d_opcode,
  output logic [SIZE_W-1:0]     in1_d_size,
  output logic [SOURCE_W-1:0]   in1_d_source,
  output logic [DATA_W-1:0]     in1_d_data,
  output logic                  out_a_valid,
  input  logic                  out_a_ready,
  output logic [2:0]            out_a_opcode,
  output logic [SIZE_W-1:0]     out_a_size,
  output logic [SOURCE_W:0]     out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [DATA_W/8-1:0]   out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,
  input  logic                  out_d_valid,
  output logic                  out_d_ready,
  input  logic [2:0]            out_d_opcode,
  input  logic [SIZE_W-1:0]     out_d_size,
  input  logic [SOURCE_W:0]     out_d_source,
  input  logic [DATA_W-1:0]     out_d_data
);

  localparam int LGBEAT = $clog2(DATA_W / 8);
  localparam int MAX_LG = (1 << SIZE_W) - 1 - LGBEAT;
  localparam int BEAT_W = (MAX_LG > 0) ? MAX_LG : 1;
  localparam int OUT_W  = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_d;
  logic                rr, lock, lock_d;
  logic [BEAT_W-1:0]   a_beats_left, a_left_d;
  logic [BEAT_W-1:0]   d_beats_left, d_left_d;
  logic [OUT_W-1:0]    outst0, outst1;

  logic                room0, room1, elig0, elig1;
  logic                gnt, a_open, a_valid_g, a_fire, a_done;
  logic [BEAT_W-1:0]   a_bm1, d_bm1;
  logic                tgt, d_fire, d_done;

  // Beats minus one; only multi-beat capable opcodes with size above a beat count.
  function automatic logic [BEAT_W-1:0] beats_m1(input logic multi_op,
                                                 input logic [SIZE_W-1:0] size);
    beats_m1 = '0;
    if (multi_op && (size > SIZE_W'(LGBEAT)))
      beats_m1 = BEAT_W'((32'd1 << (size - SIZE_W'(LGBEAT))) - 32'd1);
  endfunction

  function automatic logic [OUT_W-1:0] next_cnt(input logic [OUT_W-1:0] c,
                                                input logic inc, input logic dec);
    next_cnt = c;
    if (inc && !dec)
      next_cnt = c + OUT_W'(1);
    else if (dec && !inc && (c != '0))
      next_cnt = c - OUT_W'(1);
  endfunction

  // A channel grant and data path
  always_comb begin
    room0 = outst0 < OUT_W'(MAX_OUTST);
    room1 = outst1 < OUT_W'(MAX_OUTST);
    elig0 = in0_a_valid & room0;
    elig1 = in1_a_valid & room1;

    if (state == BURST)
      gnt = lock;
    else if (elig0 && elig1)
      gnt = rr;
    else
      gnt = elig1;

    // Inside a burst the locked master stays connected whatever its count.
    a_open    = (state == BURST) | (gnt ? room1 : room0);
    a_valid_g = gnt ? in1_a_valid : in0_a_valid;

    out_a_valid   = ~reset & a_valid_g & a_open;
    in0_a_ready   = ~reset & ~gnt & a_open & out_a_ready;
    in1_a_ready   = ~reset &  gnt & a_open & out_a_ready;
    out_a_opcode  = gnt ? in1_a_opcode  : in0_a_opcode;
    out_a_size    = gnt ? in1_a_size    : in0_a_size;
    out_a_source  = {gnt, (gnt ? in1_a_source : in0_a_source)};
    out_a_address = gnt ? in1_a_address : in0_a_address;
    out_a_mask    = gnt ? in1_a_mask    : in0_a_mask;
    out_a_data    = gnt ? in1_a_data    : in0_a_data;

    a_fire = out_a_valid & out_a_ready;
    a_bm1  = beats_m1(out_a_opcode[2:1] == 2'b00, out_a_size);
    a_done = a_fire & ((state == BURST) ? (a_beats_left == BEAT_W'(1))
                                        : (a_bm1 == '0));
  end

  // A channel FSM next state
  always_comb begin
    state_d  = state;
    lock_d   = lock;
    a_left_d = a_beats_left;
    if (a_fire) begin
      case (state)
        IDLE: begin
          if (a_bm1 != '0) begin
            state_d  = BURST;
            lock_d   = gnt;
            a_left_d = a_bm1;
          end
        end
        BURST: begin
          a_left_d = a_beats_left - BEAT_W'(1);
          if (a_beats_left == BEAT_W'(1))
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // D channel routing and beat tracking
  always_comb begin
    tgt          = out_d_source[SOURCE_W];
    out_d_ready  = ~reset & (tgt ? in1_d_ready : in0_d_ready);
    in0_d_valid  = ~reset & out_d_valid & ~tgt;
    in1_d_valid  = ~reset & out_d_valid &  tgt;
    in0_d_opcode = out_d_opcode;
    in1_d_opcode = out_d_opcode;
    in0_d_size   = out_d_size;
    in1_d_size   = out_d_size;
    in0_d_source = out_d_source[SOURCE_W-1:0];
    in1_d_source = out_d_source[SOURCE_W-1:0];
    in0_d_data   = out_d_data;
    in1_d_data   = out_d_data;

    d_fire   = out_d_valid & out_d_ready;
    d_bm1    = beats_m1(out_d_opcode == 3'd1, out_d_size);
    d_done   = d_fire & ((d_beats_left == '0) ? (d_bm1 == '0)
                                              : (d_beats_left == BEAT_W'(1)));
    d_left_d = d_beats_left;
    if (d_fire)
      d_left_d = (d_beats_left == '0) ? d_bm1 : (d_beats_left - BEAT_W'(1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lock         <= 1'b0;
      rr           <= 1'b0;
      a_beats_left <= '0;
      d_beats_left <= '0;
      outst0       <= '0;
      outst1       <= '0;
    end else begin
      state        <= state_d;
      lock         <= lock_d;
      a_beats_left <= a_left_d;
      d_beats_left <= d_left_d;
      if (a_done)
        rr <= ~gnt;
      outst0 <= next_cnt(outst0, a_done & ~gnt, d_done & ~tgt);
      outst1 <= next_cnt(outst1, a_done &  gnt, d_done &  tgt);
    end
  end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Bench for tl_ul_arbiter_2to1 (MAX_OUTST=2). Stimulus pushes expected A beats
// and D deliveries into queues; monitors pop and compare on each handshake.
module tb_tl_ul_arbiter_2to1;

  logic        clock, reset;
  logic        in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0]  in0_a_opcode, in1_a_opcode;
  logic [2:0]  in0_a_size, in1_a_size;
  logic [3:0]  in0_a_source, in1_a_source;
  logic [11:0] in0_a_address, in1_a_address;
  logic [7:0]  in0_a_mask, in1_a_mask;
  logic [63:0] in0_a_data, in1_a_data;
  logic        in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
  logic [2:0]  in0_d_opcode, in1_d_opcode, in0_d_size, in1_d_size;
  logic [3:0]  in0_d_source, in1_d_source;
  logic [63:0] in0_d_data, in1_d_data;
  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_size;
  logic [4:0]  out_a_source;
  logic [11:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode, out_d_size;
  logic [4:0]  out_d_source;
  logic [63:0] out_d_data;

  typedef struct packed {
    logic [4:0]  src;
    logic [11:0] addr;
    logic [2:0]  op;
    logic [2:0]  size;
    logic [63:0] data;
  } a_exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [63:0] data;
  } d_exp_t;

  a_exp_t qa[$];
  d_exp_t qd0[$], qd1[$];
  int n_chk = 0;
  int n_fail = 0;

  tl_ul_arbiter_2to1 #(.SOURCE_W(4), .ADDR_W(12), .DATA_W(64), .SIZE_W(3),
                       .MAX_OUTST(2)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_size(in0_a_size), .in0_a_source(in0_a_source), .in0_a_address(in0_a_address),
    .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_size(in0_d_size), .in0_d_source(in0_d_source), .in0_d_data(in0_d_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_size(in1_a_size), .in1_a_source(in1_a_source), .in1_a_address(in1_a_address),
    .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_size(in1_d_size), .in1_d_source(in1_d_source), .in1_d_data(in1_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_size(out_a_size), .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input bit m, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [11:0] ad,
                         input logic [63:0] dt, input bit push);
    a_exp_t e;
    if (m) begin
      in1_a_valid = 1'b1; in1_a_opcode = op; in1_a_size = sz;
      in1_a_source = src; in1_a_address = ad; in1_a_mask = 8'hff; in1_a_data = dt;
    end else begin
      in0_a_valid = 1'b1; in0_a_opcode = op; in0_a_size = sz;
      in0_a_source = src; in0_a_address = ad; in0_a_mask = 8'hff; in0_a_data = dt;
    end
    if (push) begin
      e = {m, src, ad, op, sz, dt};
      qa.push_back(e);
    end
  endtask

  task automatic send_d(input logic [4:0] src, input logic [2:0] op, input logic [2:0] sz,
                        input logic [63:0] dt, input bit push);
    d_exp_t e;
    out_d_valid = 1'b1; out_d_source = src; out_d_opcode = op;
    out_d_size = sz; out_d_data = dt;
    if (push) begin
      e = {op, sz, src[3:0], dt};
      if (src[4]) qd1.push_back(e);
      else        qd0.push_back(e);
    end
  endtask

  // Deliver a single-beat D response per entry, one per cycle.
  task automatic drain_d(input logic [4:0] src, input logic [2:0] op, input logic [2:0] sz);
    send_d(src, op, sz, {59'd0, src}, 1'b1);
    cyc();
    out_d_valid = 1'b0;
  endtask

  // Monitors
  always @(negedge clock) begin
    if (!reset) begin
      if (out_a_valid && out_a_ready) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL a_unexpected: got src %h addr %h expected no beat",
                   out_a_source, out_a_address);
        end else begin
          chk("a_beat", 128'({out_a_source, out_a_address, out_a_opcode, out_a_size,
                              out_a_data}), 128'(qa.pop_front()));
        end
      end
      if (in0_d_valid && in0_d_ready) begin
        if (qd0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL d0_unexpected: got src %h expected no beat", in0_d_source);
        end else begin
          chk("d0_beat", 128'({in0_d_opcode, in0_d_size, in0_d_source, in0_d_data}),
              128'(qd0.pop_front()));
        end
      end
      if (in1_d_valid && in1_d_ready) begin
        if (qd1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL d1_unexpected: got src %h expected no beat", in1_d_source);
        end else begin
          chk("d1_beat", 128'({in1_d_opcode, in1_d_size, in1_d_source, in1_d_data}),
              128'(qd1.pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    in0_a_valid = 0; in0_a_opcode = 0; in0_a_size = 0; in0_a_source = 0;
    in0_a_address = 0; in0_a_mask = 0; in0_a_data = 0;
    in1_a_valid = 0; in1_a_opcode = 0; in1_a_size = 0; in1_a_source = 0;
    in1_a_address = 0; in1_a_mask = 0; in1_a_data = 0;
    in0_d_ready = 1; in1_d_ready = 1;
    out_a_ready = 1; out_d_valid = 0; out_d_opcode = 0; out_d_size = 0;
    out_d_source = 0; out_d_data = 0;

    // Reset forces handshakes low even with live inputs
    in0_a_valid = 1'b1; out_d_valid = 1'b1;
    cyc(); cyc();
    chk("rst_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("rst_in0_a_ready", 128'(in0_a_ready), 128'(0));
    chk("rst_out_d_ready", 128'(out_d_ready), 128'(0));
    chk("rst_in0_d_valid", 128'(in0_d_valid), 128'(0));
    in0_a_valid = 1'b0; out_d_valid = 1'b0;
    reset = 1'b0;
    cyc();

    // 1: round-robin Gets, both masters fill to MAX_OUTST=2
    for (int i = 0; i < 2; i++) begin
      drive_a(0, 3'd4, 3'd3, 4'h1, 12'h100, 64'd0, 1);
      drive_a(1, 3'd4, 3'd3, 4'h2, 12'h200, 64'd0, 1);
    end
    repeat (4) cyc();
    chk("t1_full_stall", 128'(out_a_valid), 128'(0));
    in0_a_valid = 0; in1_a_valid = 0;
    for (int i = 0; i < 2; i++) begin
      drain_d(5'h01, 3'd1, 3'd3);
      drain_d(5'h12, 3'd1, 3'd3);
    end

    // 2: 8-beat PutFull from in0 locks out in1
    drive_a(1, 3'd4, 3'd3, 4'h2, 12'h208, 64'd0, 0);
    for (int b = 0; b < 8; b++) begin
      drive_a(0, 3'd0, 3'd6, 4'h3, 12'h040, 64'hA0 + 64'(b), 1);
      #1 chk("t2_in1_locked", 128'(in1_a_ready), 128'(0));
      cyc();
    end
    drive_a(1, 3'd4, 3'd3, 4'h2, 12'h208, 64'd0, 1);
    drive_a(0, 3'd4, 3'd3, 4'h4, 12'h300, 64'd0, 1);
    #1 chk("t2_in1_9th", 128'(in1_a_ready), 128'(1));
    cyc();
    chk("t2_in0_next", 128'(in0_a_ready), 128'(1));
    cyc();
    in0_a_valid = 0; in1_a_valid = 0;
    drain_d(5'h03, 3'd0, 3'd6);
    drain_d(5'h12, 3'd1, 3'd3);
    drain_d(5'h04, 3'd1, 3'd3);

    // 3: third Get stalls until one response returns
    drive_a(0, 3'd4, 3'd3, 4'h5, 12'h010, 64'd0, 1); cyc();
    drive_a(0, 3'd4, 3'd3, 4'h6, 12'h018, 64'd0, 1); cyc();
    drive_a(0, 3'd4, 3'd3, 4'h7, 12'h020, 64'd0, 0);
    #1 chk("t3_stall", 128'(in0_a_ready), 128'(0));
    chk("t3_no_valid", 128'(out_a_valid), 128'(0));
    cyc();
    send_d(5'h05, 3'd1, 3'd3, 64'h55, 1);
    #1 chk("t3_stall_dcycle", 128'(in0_a_ready), 128'(0));
    cyc();
    out_d_valid = 0;
    drive_a(0, 3'd4, 3'd3, 4'h7, 12'h020, 64'd0, 1);
    #1 chk("t3_release", 128'(in0_a_ready), 128'(1));
    cyc();
    in0_a_valid = 0;
    drain_d(5'h06, 3'd1, 3'd3);
    drain_d(5'h07, 3'd1, 3'd3);

    // 4: in1 A completion coincides with its last D beat
    drive_a(1, 3'd4, 3'd3, 4'h3, 12'h400, 64'd0, 1); cyc();
    out_a_ready = 0;
    drive_a(1, 3'd4, 3'd3, 4'h3, 12'h408, 64'd0, 0);
    in1_d_ready = 0;
    send_d(5'b1_0011, 3'd1, 3'd3, 64'hBEEF, 0);
    #1 chk("t4_d_backpressure", 128'(out_d_ready), 128'(0));
    chk("t4_d1_valid", 128'(in1_d_valid), 128'(1));
    chk("t4_d0_quiet", 128'(in0_d_valid), 128'(0));
    chk("t4_d1_source", 128'(in1_d_source), 128'(4'b0011));
    cyc();
    in1_d_ready = 1; out_a_ready = 1;
    drive_a(1, 3'd4, 3'd3, 4'h3, 12'h408, 64'd0, 1);
    send_d(5'b1_0011, 3'd1, 3'd3, 64'hBEEF, 1);
    cyc();
    out_d_valid = 0;
    drive_a(1, 3'd4, 3'd3, 4'h4, 12'h410, 64'd0, 1); cyc();
    drive_a(1, 3'd4, 3'd3, 4'h5, 12'h418, 64'd0, 0);
    #1 chk("t4_outst1_full", 128'(in1_a_ready), 128'(0));
    cyc();
    in1_a_valid = 0;
    drain_d(5'h13, 3'd1, 3'd3);
    drain_d(5'h14, 3'd1, 3'd3);

    // 5a: 4-beat AccessAckData releases in0 only after its last beat
    drive_a(0, 3'd4, 3'd5, 4'h1, 12'h500, 64'd0, 1); cyc();
    drive_a(0, 3'd4, 3'd3, 4'h2, 12'h508, 64'd0, 1); cyc();
    drive_a(0, 3'd4, 3'd3, 4'h3, 12'h510, 64'd0, 0);
    for (int k = 0; k < 4; k++) begin
      send_d(5'h01, 3'd1, 3'd5, 64'hD0 + 64'(k), 1);
      #1 chk("t5_hold_multibeat", 128'(in0_a_ready), 128'(0));
      cyc();
    end
    out_d_valid = 0;
    drive_a(0, 3'd4, 3'd3, 4'h3, 12'h510, 64'd0, 1);
    #1 chk("t5_release", 128'(in0_a_ready), 128'(1));
    cyc();
    in0_a_valid = 0;
    drain_d(5'h02, 3'd1, 3'd3);
    drain_d(5'h03, 3'd1, 3'd3);

    // 5b: in1 4-beat PutPartial with a stalled beat; in0 waits for the end
    drive_a(0, 3'd4, 3'd3, 4'h4, 12'h520, 64'd0, 0);
    drive_a(1, 3'd1, 3'd5, 4'h6, 12'h600, 64'hB0, 1);
    cyc();
    out_a_ready = 0;
    drive_a(1, 3'd1, 3'd5, 4'h6, 12'h600, 64'hB1, 0);
    repeat (2) begin
      #1 chk("t5_burst_valid", 128'(out_a_valid), 128'(1));
      chk("t5_in0_locked_stall", 128'(in0_a_ready), 128'(0));
      cyc();
    end
    out_a_ready = 1;
    for (int b = 1; b < 4; b++) begin
      drive_a(1, 3'd1, 3'd5, 4'h6, 12'h600, 64'hB0 + 64'(b), 1);
      #1 chk("t5_in0_locked", 128'(in0_a_ready), 128'(0));
      cyc();
    end
    in1_a_valid = 0;
    drive_a(0, 3'd4, 3'd3, 4'h4, 12'h520, 64'd0, 1);
    #1 chk("t5_after_burst", 128'(in0_a_ready), 128'(1));
    cyc();
    in0_a_valid = 0;

    // 6: async reset mid-burst (outst0=outst1=1 and rr=1 going in)
    for (int b = 0; b < 3; b++) begin
      drive_a(0, 3'd0, 3'd6, 4'h2, 12'h700, 64'hC0 + 64'(b), 1);
      cyc();
    end
    drive_a(0, 3'd0, 3'd6, 4'h2, 12'h700, 64'hC3, 0);
    drive_a(1, 3'd4, 3'd3, 4'h7, 12'h710, 64'd0, 0);
    #2 reset = 1'b1;
    #1 chk("t6_rst_out_a_valid", 128'(out_a_valid), 128'(0));
    chk("t6_rst_in0_a_ready", 128'(in0_a_ready), 128'(0));
    chk("t6_rst_in1_a_ready", 128'(in1_a_ready), 128'(0));
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_a(0, 3'd4, 3'd3, 4'h1, 12'h720, 64'd0, 1);
      drive_a(1, 3'd4, 3'd3, 4'h7, 12'h710, 64'd0, 1);
    end
    repeat (4) cyc();
    in0_a_valid = 0; in1_a_valid = 0;
    cyc();

    chk("end_qa_empty", 128'(qa.size()), 128'(0));
    chk("end_qd0_empty", 128'(qd0.size()), 128'(0));
    chk("end_qd1_empty", 128'(qd1.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_arbiter_2to1.md
Name: tl_ul_arbiter_2to1

Overview:
- Shares one TileLink-UL slave port (the fragmenter input inside the interconnect coupler) between two TL-UL masters.
- A channel: round-robin arbitration, with the grant locked for the full duration of a multi-beat Put burst. The requester ID is appended as the source MSB.
- D channel: responses are routed back by that MSB, which is stripped before delivery.
- Per-requester outstanding-transaction limits provide backpressure before the shared port saturates.

Parameters:
- SOURCE_W, 4: source width on each master port. The output source is SOURCE_W+1 bits.
- ADDR_W, 12: address width.
- DATA_W, 64: data width. Beat bytes = DATA_W/8 = 8, so LGBEAT = 3.
- SIZE_W, 3: size field width. Maximum message size is 2^7 = 128 B, which is 16 beats.
- MAX_OUTST, 4: maximum outstanding messages per requester. Range 1..15.

Ports (N = 0,1; each inN_ line denotes two ports):
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- inN_a_valid  in  1  master N A-channel valid.
- inN_a_ready  out  1  master N A-channel ready.
- inN_a_opcode  in  3  A opcode.
- inN_a_size  in  SIZE_W  A size (log2 bytes).
- inN_a_source  in  SOURCE_W  A source.
- inN_a_address  in  ADDR_W  A address.
- inN_a_mask  in  DATA_W/8  A mask.
- inN_a_data  in  DATA_W  A data.
- inN_d_valid  out  1  D valid to master N.
- inN_d_ready  in  1  D ready from master N.
- inN_d_opcode  out  3  D opcode.
- inN_d_size  out  SIZE_W  D size.
- inN_d_source  out  SOURCE_W  D source.
- inN_d_data  out  DATA_W  D data.
- out_a_valid, out_a_opcode, out_a_size, out_a_address, out_a_mask, out_a_data  out  per field  shared A channel.
- out_a_source  out  SOURCE_W+1  shared A source.
- out_a_ready  in  1  shared A ready.
- out_d_valid, out_d_opcode, out_d_size, out_d_data  in  per field  shared D channel.
- out_d_source  in  SOURCE_W+1  shared D source.
- out_d_ready  out  1  shared D ready.

Behaviour:
- Reset is asynchronous and active-high: reset is asynchronous and active-high. On assertion:
  - state=IDLE, rr=0, a_beats_left=0, d_beats_left=0, outst0=outst1=0.
  - out_a_valid, inN_a_ready, inN_d_valid and out_d_ready are all forced to 0 while reset is high.
  - Reset mid-burst abandons the burst with no drain; upstream and downstream reset together.
- Beat count of an A message:
  - PutFull (opcode 0) or PutPartial (opcode 1) with size>3: 2^(size-3) beats.
  - All other A messages: 1 beat.
- Beat count of a D message:
  - AccessAckData (opcode 1) with size>3: 2^(size-3) beats.
  - All other D messages: 1 beat.
- Eligibility: eligN = inN_a_valid & (outstN < MAX_OUTST).
- IDLE state (combinational grant, zero added latency):
  - If both are eligible, grant g = rr. Otherwise g = the eligible one.
  - out_a_valid = elig_g; out_a_* = in_g_a_*; out_a_source = {g, in_g_a_source}.
  - in_g_a_ready = out_a_ready. The other inN_a_ready = 0.
  - On fire (valid&ready) with a single-beat message: message complete, stay in IDLE.
  - On fire with a multi-beat message: lock=g, a_beats_left=beats-1, go to BURST.
- BURST state:
  - Only the master equal to lock is connected, regardless of its outstanding count.
  - Each fire decrements a_beats_left. The fire with a_beats_left==1 completes the message and returns to IDLE.
  - The other master stays stalled even if it is valid.
- On A message completion by requester g:
  - rr <= ~g.
  - outst_g increments.
- D routing: tgt = out_d_source[SOURCE_W].
  - in_tgt_d_valid = out_d_valid; in_tgt_d_* = out_d_* with source[SOURCE_W-1:0].
  - out_d_ready = in_tgt_d_ready. The other inN_d_valid = 0.
- D beat tracking:
  - d_beats_left counts remaining beats of the current D message; 0 means the next beat is a first beat.
  - On the last D beat fire (single-beat message, or d_beats_left==1), outst_tgt decrements.
- Simultaneous increment and decrement of the same counter in one cycle: the counter is unchanged.
- An A completion never occurs when outst==MAX_OUTST, because eligibility gating prevents it. A D decrement at 0 is a protocol error; the counter saturates at 0.
- A and D paths are independent. A D fire may occur in the same cycle as any A activity.
- out_a_valid must not deassert mid-burst while unfired. Master compliance is required; the arbiter does not check it.

Test Plan:
- Both masters continuously offer single-beat Get (opcode 4, size 3), out_a_ready=1, with D returned promptly: grants alternate 0,1,0,1; out_a_source MSB toggles each cycle; no master starves.
- in0 issues PutFull size 6 (8 beats) while in1 is valid throughout: in1_a_ready=0 for all 8 beats; in1 is granted on the 9th cycle; rr=1 after the burst.
- MAX_OUTST=2 and in0 issues 3 Gets with D withheld: the third Get stalls (in0_a_ready=0); one AccessAckData D fire releases it the next cycle; outst0 returns to 0 after all responses.
- Simultaneous: in1 A completes in the same cycle as its last D beat: outst1 unchanged. D source 5'b1_0011 is delivered to in1 with source 4'b0011, and in1_d_ready=0 backpressures out_d_ready.
- AccessAckData size 5 (4 beats) to in0: outst0 decrements only on the 4th beat; an interleaved out_a_ready=0 mid A-burst holds a_beats_left.
- Reset asserted asynchronously mid-burst (a_beats_left=5): state goes IDLE and all counters go to 0 immediately; after deassert, in0 is granted first when both are valid.
